latch_bank_arbiter: RTL and testbench
=====================================

// Module: latch_bank_arbiter
// PURPOSE
//  Shares one 28-bit transparent D-latch bank (per-bit Dlat, common active-high enable) between two requesters.
//  Round-robin arbitration picks one requester at a time.
//  The block sequences the latch enable so data is stable before, during and after the transparent window.
//  It then presents the latched word to a single consumer with a valid/ready handshake.
//  It sits between the producers and the latch bank; the latch bank's outputs feed back into latch_q.
// PARAMETERS
//  WIDTH        28  data width; must match the latch bank width
//  OPEN_CYCLES  1   cycles latch_en is held high per capture; legal range 1..15
// PORTS
//  clk          in   1      system clock; all state changes on rising edge
//  rst          in   1      synchronous reset, active-high
//  req0_valid   in   1      requester 0 has a word to latch
//  req0_data    in   WIDTH  requester 0 word
//  req0_ready   out  1      requester 0 word accepted this cycle
//  req1_valid   in   1      requester 1 has a word to latch
//  req1_data    in   WIDTH  requester 1 word
//  req1_ready   out  1      requester 1 word accepted this cycle
//  latch_en     out  1      enable to the latch bank; registered
//  latch_din    out  WIDTH  data to the latch bank D inputs; registered
//  latch_q      in   WIDTH  latch bank Q outputs
//  out_valid    out  1      latched word available on out_data
//  out_data     out  WIDTH  equals latch_q; only meaningful while out_valid=1
//  out_src      out  1      source of the current word: 0 = req0, 1 = req1
//  out_ready    in   1      consumer takes the word
//  busy         out  1      high in every state except IDLE
// BEHAVIOUR
//  Reset values: state=IDLE, latch_en=0, latch_din=0, out_valid=0, out_src=0, last_grant=1, counter=0.
//  FSM states: IDLE -> SETUP -> OPEN -> HOLD -> FULL -> IDLE.
//  IDLE:
//   - Grant is combinational: a lone valid requester wins.
//   - If both are valid, the requester != last_grant wins.
//   - reqN_ready = (state==IDLE) & grantN. At most one ready is high in any cycle.
//   - On accept: latch_din <= granted data, out_src <= grant, last_grant <= grant, next state SETUP.
//  SETUP: 1 cycle; latch_en=0; latch_din stable (setup time); next OPEN, counter <= OPEN_CYCLES-1.
//  OPEN:
//   - latch_en=1 for exactly OPEN_CYCLES consecutive cycles; counter decrements each cycle.
//   - Leave to HOLD when counter==0.
//  HOLD: 1 cycle; latch_en=0; latch_din unchanged (hold time); next FULL.
//  FULL: out_valid=1; on out_ready=1 next state IDLE; out_valid deasserts the following cycle.
//  latch_din changes only on an IDLE accept or on reset. latch_en is high only in OPEN.
//  Latency: accept at cycle T gives out_valid at T+3+OPEN_CYCLES (T+4 for the default).
//  Back-to-back throughput: one word per 4+OPEN_CYCLES cycles; no new accept while busy.
//  Requests seen while busy are ignored, not queued; the requester holds valid until its ready.
//  A requester dropping valid during IDLE without a ready is legal; nothing is recorded.
//  A second pending requester is served next, because last_grant alternates.
//  Reset mid-operation (any state): next edge forces IDLE, latch_en=0, out_valid=0.
//   - Latch contents become don't-care; no ready is asserted in the reset cycle.
//  out_ready while not in FULL is ignored.
// TESTING
//  1. Reset, then req0_valid=1 with data 28'h0ABCDEF at T:
//     -> req0_ready=1 at T; latch_en=1 only at T+2; out_valid=1 at T+4, out_data=28'h0ABCDEF, out_src=0.
//  2. Both valid from reset (req0=28'h1, req1=28'h2), out_ready tied 1:
//     -> grants alternate req0, req1, req0, ...; each ready is a one-cycle pulse.
//  3. OPEN_CYCLES=3:
//     -> latch_en high for exactly 3 consecutive cycles; out_valid at accept+6.
//  4. out_ready held 0 for 10 cycles in FULL:
//     -> out_valid stays 1; both readys stay 0; latch_en stays 0; busy=1.
//  5. rst pulsed during OPEN:
//     -> latch_en=0 and busy=0 the next cycle; first grant after reset goes to req0.
//  6. req1_data changes while in SETUP/OPEN/HOLD:
//     -> latch_din and out_data keep the accepted word.

Source files
------------

// File: rtl/latch_bank_arbiter.sv
// latch_bank_arbiter
// Round-robin arbiter in front of a shared transparent latch bank. It captures
// one requester's word, sequences the latch enable with setup and hold cycles
// around the transparent window, then offers the latched word to a consumer
// through a valid/ready handshake.
module latch_bank_arbiter #(
    parameter int WIDTH       = 28,
    parameter int OPEN_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             latch_en,
    output logic [WIDTH-1:0] latch_din,
    input  logic [WIDTH-1:0] latch_q,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        OPEN  = 3'd2,
        HOLD  = 3'd3,
        FULL  = 3'd4
    } state_t;

    // Counter preload: OPEN is entered with OPEN_CYCLES-1 and left at zero.
    localparam logic [3:0] OPEN_LOAD = 4'(OPEN_CYCLES - 1);

    state_t     state;
    logic       last_grant;
    logic [3:0] counter;
    logic       grant_any;
    logic       grant;
    logic       accept;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        grant_any = req0_valid | req1_valid;
        grant     = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    // A word is taken only in IDLE, and never in a cycle where reset is asserted.
    assign accept     = (state == IDLE) && grant_any && !rst;
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign busy       = (state != IDLE);
    assign out_data   = latch_q;

    // Capture sequencer: IDLE -> SETUP -> OPEN (OPEN_CYCLES) -> HOLD -> FULL -> IDLE.
    always_ff @(posedge clk) begin
        // NOTE: all sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= IDLE;
            latch_en   <= 1'b0;
            latch_din  <= '0;
            out_valid  <= 1'b0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
            counter    <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        latch_din  <= grant ? req1_data : req0_data;
                        out_src    <= grant;
                        last_grant <= grant;
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    // latch_din has been stable for a full cycle; open the bank.
                    state    <= OPEN;
                    counter  <= OPEN_LOAD;
                    latch_en <= 1'b1;
                end
                OPEN: begin
                    if (counter == 4'd0) begin
                        state    <= HOLD;
                        latch_en <= 1'b0;
                    end else begin
                        counter <= counter - 4'd1;
                    end
                end
                HOLD: begin
                    // Bank closed; latch_din is held one more cycle for hold time.
                    state     <= FULL;
                    out_valid <= 1'b1;
                end
                FULL: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    latch_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// tb_latch_bank_arbiter
// Drives two arbiter instances (OPEN_CYCLES = 1 and 3) from shared requester
// and consumer stimulus. Each instance has its own behavioural latch bank and
// its own reference model, expressed as elapsed cycles since the last accept.
module tb_latch_bank_arbiter;

    localparam int W   = 28;
    localparam int OC0 = 1;
    localparam int OC1 = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         v0, v1, ordy;
    logic [W-1:0] d0, d1;

    logic         rdy0 [2];
    logic         rdy1 [2];
    logic         len  [2];
    logic [W-1:0] din  [2];
    logic [W-1:0] bank_q [2];
    logic         ov   [2];
    logic [W-1:0] odata [2];
    logic         osrc [2];
    logic         bsy  [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state, per instance
    bit           m_busy [2];
    int           m_tacc [2];
    bit           m_last [2];
    bit           m_src  [2];
    logic [W-1:0] m_din  [2];

    always #5 clk = ~clk;

    latch_bank_arbiter #(.WIDTH(W), .OPEN_CYCLES(OC0)) dut0 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0[0]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1[0]),
        .latch_en(len[0]), .latch_din(din[0]), .latch_q(bank_q[0]),
        .out_valid(ov[0]), .out_data(odata[0]), .out_src(osrc[0]),
        .out_ready(ordy), .busy(bsy[0])
    );

    latch_bank_arbiter #(.WIDTH(W), .OPEN_CYCLES(OC1)) dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(v0), .req0_data(d0), .req0_ready(rdy0[1]),
        .req1_valid(v1), .req1_data(d1), .req1_ready(rdy1[1]),
        .latch_en(len[1]), .latch_din(din[1]), .latch_q(bank_q[1]),
        .out_valid(ov[1]), .out_data(odata[1]), .out_src(osrc[1]),
        .out_ready(ordy), .busy(bsy[1])
    );

    // Behavioural transparent latch banks
    always_latch begin
        if (len[0]) bank_q[0] <= din[0];
    end
    always_latch begin
        if (len[1]) bank_q[1] <= din[1];
    end

    function automatic int oc_of(input int i);
        return (i == 0) ? OC0 : OC1;
    endfunction

    task automatic check(input string tag, input int inst, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d] cycle %0d observed=%0h expected=%0h", tag, inst, cyc, obs, exp);
        end
    endtask

    // Expected winner in IDLE from the round-robin rule
    function automatic void pick(input int i, output bit any, output bit g);
        any = v0 | v1;
        if (v0 && v1) g = ~m_last[i];
        else          g = v1;
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            bit any, g;
            int el;
            bit e_en, e_ov;
            pick(i, any, g);
            el   = cyc - m_tacc[i];
            e_en = m_busy[i] && (el >= 2) && (el <= 1 + oc_of(i));
            e_ov = m_busy[i] && (el >= 3 + oc_of(i));
            check("req0_ready", i, 32'(rdy0[i]), 32'(!rst && !m_busy[i] && any && !g));
            check("req1_ready", i, 32'(rdy1[i]), 32'(!rst && !m_busy[i] && any && g));
            check("busy",       i, 32'(bsy[i]),  32'(m_busy[i]));
            check("latch_en",   i, 32'(len[i]),  32'(e_en));
            check("out_valid",  i, 32'(ov[i]),   32'(e_ov));
            check("latch_din",  i, 32'(din[i]),  32'(m_din[i]));
            check("out_src",    i, 32'(osrc[i]), 32'(m_src[i]));
            if (e_ov) check("out_data", i, 32'(odata[i]), 32'(m_din[i]));
        end
    endtask

    task automatic update_model();
        for (int i = 0; i < 2; i++) begin
            bit any, g;
            pick(i, any, g);
            if (rst) begin
                m_busy[i] = 1'b0;
                m_last[i] = 1'b1;
                m_src[i]  = 1'b0;
                m_din[i]  = '0;
            end else if (!m_busy[i]) begin
                if (any) begin
                    m_busy[i] = 1'b1;
                    m_tacc[i] = cyc;
                    m_src[i]  = g;
                    m_last[i] = g;
                    m_din[i]  = g ? d1 : d0;
                end
            end else if ((cyc - m_tacc[i] >= 3 + oc_of(i)) && ordy) begin
                m_busy[i] = 1'b0;
            end
        end
    endtask

    // One clock: drive at negedge, check shortly after, advance model at posedge
    task automatic cycle(input logic r, input logic a0, input logic a1,
                         input logic [W-1:0] x0, input logic [W-1:0] x1, input logic orr);
        @(negedge clk);
        rst = r; v0 = a0; v1 = a1; d0 = x0; d1 = x1; ordy = orr;
        #1;
        check_all();
        @(posedge clk);
        update_model();
        cyc++;
    endtask

    task automatic rand_cycle(input int p_rst, input int p_v, input int p_rdy);
        cycle(($urandom_range(99) < p_rst), ($urandom_range(99) < p_v), ($urandom_range(99) < p_v),
              W'($urandom), W'($urandom), ($urandom_range(99) < p_rdy));
    endtask

    initial begin
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; d0 = '0; d1 = '0; ordy = 1'b0;
        // First edge brings the DUTs out of their unknown power-up state
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_tacc[i] = 0; m_last[i] = 1'b1; m_src[i] = 1'b0; m_din[i] = '0;
        end

        // Reset state
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, '0, '0, 1'b1);

        // Lone req0 with 0ABCDEF, consumer always ready
        cycle(1'b0, 1'b1, 1'b0, 28'h0ABCDEF, 28'h0, 1'b1);
        for (int k = 0; k < 9; k++) cycle(1'b0, 1'b0, 1'b0, 28'h0, 28'h0, 1'b1);

        // Both requesters valid, grants alternate
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        for (int k = 0; k < 30; k++) cycle(1'b0, 1'b1, 1'b1, 28'h1, 28'h2, 1'b1);

        // Consumer stalls in FULL, requester data churns meanwhile
        for (int k = 0; k < 18; k++) cycle(1'b0, 1'b1, 1'b1, W'($urandom), W'($urandom), 1'b0);
        for (int k = 0; k < 4; k++)  cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1);

        // Reset pulse during OPEN; first grant afterwards goes to req0
        cycle(1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 28'h5555555, 28'h0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 28'h0, 28'hAAAAAAA, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 28'h0, 28'hAAAAAAA, 1'b1);
        for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, 1'b1, 28'h1234567, 28'h7654321, 1'b1);

        // Random traffic with occasional resets and back-pressure
        for (int k = 0; k < 600; k++) rand_cycle(2, 60, 50);
        for (int k = 0; k < 200; k++) rand_cycle(0, 90, 90);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
